// File: rtl/rx_xxpad_pkg.sv
// Shared types for the AIB pad RX enable/capture logic: FSM states, pair phase
// and the pad operating-mode encoding also used by the TX enable logic.
package rx_xxpad_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_ACTIVE = 2'd2
    } rx_state_t;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } rx_phase_t;

    typedef enum logic [2:0] {
        MODE_IDLE  = 3'd0,
        MODE_STRAP = 3'd1,
        MODE_NOPWR = 3'd2,
        MODE_ASYNC = 3'd3,
        MODE_SYNC  = 3'd4
    } pad_mode_t;

    // Strap beats power-good, which beats async, which beats the sync enable.
    function automatic pad_mode_t decode_mode(input logic rst_strap, input logic pg,
                                              input logic async_en, input logic en);
        if (rst_strap)     return MODE_STRAP;
        else if (!pg)      return MODE_NOPWR;
        else if (async_en) return MODE_ASYNC;
        else if (en)       return MODE_SYNC;
        else               return MODE_IDLE;
    endfunction

endpackage

// File: rtl/rx_en_capture_xxpad_pair_capture.sv
// Pad sample register with SDR duplication or DDR even/odd pairing and a
// one-cycle valid strobe; any break in cap_en discards a partial pair.
module rx_ddr_pair_capture
    import rx_xxpad_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cap_en,
    input  logic clr,
    input  logic sdr_mode,
    input  logic pad_data,
    output logic data_even,
    output logic data_odd,
    output logic data_vld
);

    rx_phase_t phase_q;
    logic      pend_q;
    logic      samp_q;
    logic      even_stg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_EVEN;
            pend_q    <= 1'b0;
            data_vld  <= 1'b0;
            data_even <= 1'b0;
            data_odd  <= 1'b0;
        end else if (clr) begin
            phase_q   <= PH_EVEN;
            pend_q    <= 1'b0;
            data_vld  <= 1'b0;
            data_even <= 1'b0;
            data_odd  <= 1'b0;
        end else if (!cap_en) begin
            phase_q  <= PH_EVEN;
            pend_q   <= 1'b0;
            data_vld <= 1'b0;
        end else if (sdr_mode) begin
            phase_q  <= PH_EVEN;
            pend_q   <= 1'b1;
            data_vld <= pend_q;
            if (pend_q) begin
                data_even <= samp_q;
                data_odd  <= samp_q;
            end
        end else if (phase_q == PH_EVEN) begin
            // A completed pair is presented on the same edge the next even bit lands.
            phase_q  <= PH_ODD;
            pend_q   <= 1'b0;
            data_vld <= pend_q;
            if (pend_q) begin
                data_even <= even_stg_q;
                data_odd  <= samp_q;
            end
        end else begin
            phase_q  <= PH_EVEN;
            pend_q   <= 1'b1;
            data_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            samp_q <= pad_data;
            if (!sdr_mode && phase_q == PH_ODD) begin
                even_stg_q <= samp_q;
            end
        end
    end

endmodule

// File: rtl/rx_en_capture_xxpad.sv
// RX-side pad enable logic: buffer and weak-pull enables, warm-up FSM, gated
// async bypass, and SDR/DDR capture through rx_ddr_pair_capture.
module rx_en_capture_xxpad
    import rx_xxpad_pkg::*;
#(
    parameter int WARMUP_CYC = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_data,
    input  logic pwrgoodrx,
    input  logic pwrgood,
    input  logic rst_strap,
    input  logic rx_en,
    input  logic rx_async_en,
    input  logic sdr_mode_en,
    input  logic gen1_en,
    input  logic wk_pu_en,
    input  logic wk_pd_en,
    output logic rx_buf_en_gen1,
    output logic rx_buf_en_gen2,
    output logic wkpu_en,
    output logic wkpd_en,
    output logic rx_async_data,
    output logic rx_data_even,
    output logic rx_data_odd,
    output logic rx_data_vld,
    output logic rx_ready
);

    localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP_CYC == 0) ? '0 : CNT_W'(WARMUP_CYC - 1);

    pad_mode_t        mode;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pg, wk;
    logic             sdr_q, gen1_q, mode_chg, warm_done;
    logic             async_active_q, sel_gen1, cap_en;

    assign pg        = pwrgoodrx & pwrgood;
    assign wk        = wk_pu_en ^ wk_pd_en;
    assign mode      = decode_mode(rst_strap, pg, rx_async_en, rx_en);
    assign mode_chg  = (sdr_mode_en != sdr_q) || (gen1_en != gen1_q);
    assign warm_done = (WARMUP_CYC == 0) || (cnt_q == WARM_LAST);
    assign sel_gen1  = gen1_en | sdr_mode_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mode != MODE_SYNC) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end
                ST_WARMUP: begin
                    if (mode_chg) begin
                        cnt_d = '0;
                    end else if (warm_done) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (mode_chg) begin
                        state_d = ST_WARMUP;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            cnt_q          <= '0;
            sdr_q          <= 1'b0;
            gen1_q         <= 1'b0;
            rx_buf_en_gen1 <= 1'b0;
            rx_buf_en_gen2 <= 1'b0;
            wkpu_en        <= 1'b0;
            wkpd_en        <= 1'b0;
            async_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sdr_q          <= sdr_mode_en;
            gen1_q         <= gen1_en;
            async_active_q <= (mode == MODE_ASYNC);
            // Strap forces a pull-down; otherwise pulls follow a single unambiguous request.
            wkpu_en <= (mode != MODE_STRAP) && (mode != MODE_NOPWR) && wk && wk_pu_en;
            wkpd_en <= (mode == MODE_STRAP) ||
                       ((mode != MODE_NOPWR) && wk && wk_pd_en);
            if (mode == MODE_ASYNC) begin
                rx_buf_en_gen1 <= 1'b1;
                rx_buf_en_gen2 <= 1'b0;
            end else if (state_d != ST_OFF) begin
                rx_buf_en_gen1 <= sel_gen1;
                rx_buf_en_gen2 <= ~sel_gen1;
            end else begin
                rx_buf_en_gen1 <= 1'b0;
                rx_buf_en_gen2 <= 1'b0;
            end
        end
    end

    assign rx_ready      = (state_q == ST_ACTIVE);
    assign rx_async_data = pad_data & async_active_q;
    assign cap_en        = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);

    rx_ddr_pair_capture u_pair (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (cap_en),
        .clr       (!pg),
        .sdr_mode  (sdr_mode_en),
        .pad_data  (pad_data),
        .data_even (rx_data_even),
        .data_odd  (rx_data_odd),
        .data_vld  (rx_data_vld)
    );

endmodule

// File: tb/tb_rx_en_capture_xxpad.sv
// Directed bench for rx_en_capture_xxpad: status checks inline, captured
// even/odd pairs checked by a scoreboard monitor on rx_data_vld.
module tb_rx_en_capture_xxpad;

    typedef struct packed {
        logic even;
        logic odd;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pad_data = 1'b0, pwrgoodrx = 1'b1, pwrgood = 1'b1, rst_strap = 1'b0;
    logic rx_en = 1'b0, rx_async_en = 1'b0, sdr_mode_en = 1'b0, gen1_en = 1'b1;
    logic wk_pu_en = 1'b0, wk_pd_en = 1'b0;
    logic rx_buf_en_gen1, rx_buf_en_gen2, wkpu_en, wkpd_en, rx_async_data;
    logic rx_data_even, rx_data_odd, rx_data_vld, rx_ready;

    int    vectors = 0;
    int    miscompares = 0;
    pair_t sb_q[$];

    always #5 clk = ~clk;

    rx_en_capture_xxpad #(.WARMUP_CYC(8), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pad_data       (pad_data),
        .pwrgoodrx      (pwrgoodrx),
        .pwrgood        (pwrgood),
        .rst_strap      (rst_strap),
        .rx_en          (rx_en),
        .rx_async_en    (rx_async_en),
        .sdr_mode_en    (sdr_mode_en),
        .gen1_en        (gen1_en),
        .wk_pu_en       (wk_pu_en),
        .wk_pd_en       (wk_pd_en),
        .rx_buf_en_gen1 (rx_buf_en_gen1),
        .rx_buf_en_gen2 (rx_buf_en_gen2),
        .wkpu_en        (wkpu_en),
        .wkpd_en        (wkpd_en),
        .rx_async_data  (rx_async_data),
        .rx_data_even   (rx_data_even),
        .rx_data_odd    (rx_data_odd),
        .rx_data_vld    (rx_data_vld),
        .rx_ready       (rx_ready)
    );

    // Monitor: every valid strobe must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n && rx_data_vld) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_vld: got even=%0b odd=%0b, none expected", rx_data_even, rx_data_odd);
            end else begin
                pair_t e;
                e = sb_q.pop_front();
                if (rx_data_even !== e.even || rx_data_odd !== e.odd) begin
                    miscompares++;
                    $display("FAIL pair: got even=%0b odd=%0b, expected even=%0b odd=%0b",
                             rx_data_even, rx_data_odd, e.even, e.odd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic e, input logic o);
        pair_t p;
        p.even = e;
        p.odd  = o;
        sb_q.push_back(p);
    endtask

    // Counts edges until rx_ready, bounded so a stuck FSM still reaches the summary.
    task automatic wait_ready(input string name, input int exp_edges);
        int n = 0;
        while (!rx_ready && n < 30) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            miscompares++;
            vectors++;
            $display("FAIL %s_timeout: got rx_ready=0 after %0d edges, expected 1", name, n);
        end else begin
            chk_int(name, n, exp_edges);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, rx_ready, 1'b0);
        chk({tag, "_gen1"}, rx_buf_en_gen1, 1'b0);
        chk({tag, "_gen2"}, rx_buf_en_gen2, 1'b0);
        chk({tag, "_wkpu"}, wkpu_en, 1'b0);
        chk({tag, "_wkpd"}, wkpd_en, 1'b0);
        chk({tag, "_vld"}, rx_data_vld, 1'b0);
        chk({tag, "_even"}, rx_data_even, 1'b0);
        chk({tag, "_odd"}, rx_data_odd, 1'b0);
        chk({tag, "_async"}, rx_async_data, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Warm-up timing, gen1 DDR
        rx_en = 1'b1;
        tick();
        chk("warm_gen1", rx_buf_en_gen1, 1'b1);
        chk("warm_gen2", rx_buf_en_gen2, 1'b0);
        chk("warm_ready", rx_ready, 1'b0);
        repeat (7) tick();
        chk("warm_ready_e8", rx_ready, 1'b0);
        tick();
        chk("warm_ready_e9", rx_ready, 1'b1);

        // DDR pairing: pad 1,0,0,1 -> (1,0) then (0,1)
        push(1'b1, 1'b0);
        push(1'b0, 1'b1);
        pad_data = 1'b1; tick(); chk("ddr_vld1", rx_data_vld, 1'b0);
        pad_data = 1'b0; tick(); chk("ddr_vld2", rx_data_vld, 1'b0);
        pad_data = 1'b0; tick(); chk("ddr_vld3", rx_data_vld, 1'b1);
        pad_data = 1'b1; tick(); chk("ddr_vld4", rx_data_vld, 1'b0);
        pad_data = 1'b0; tick(); chk("ddr_vld5", rx_data_vld, 1'b1);
        rx_en = 1'b0;
        tick();
        chk("ddr_off_vld", rx_data_vld, 1'b0);
        chk("ddr_off_ready", rx_ready, 1'b0);
        chk("ddr_off_gen1", rx_buf_en_gen1, 1'b0);

        // SDR capture with gen1_en=0 (SDR still selects gen1 buffer)
        sdr_mode_en = 1'b1;
        gen1_en = 1'b0;
        rx_en = 1'b1;
        tick();
        chk("sdr_gen1", rx_buf_en_gen1, 1'b1);
        chk("sdr_gen2", rx_buf_en_gen2, 1'b0);
        wait_ready("sdr_warm", 8);
        push(1'b1, 1'b1);
        push(1'b1, 1'b1);
        push(1'b0, 1'b0);
        pad_data = 1'b1; tick(); chk("sdr_vld1", rx_data_vld, 1'b0);
        pad_data = 1'b1; tick(); chk("sdr_vld2", rx_data_vld, 1'b1);
        pad_data = 1'b0; tick(); chk("sdr_vld3", rx_data_vld, 1'b1);
        tick(); chk("sdr_vld4", rx_data_vld, 1'b1);
        rx_en = 1'b0;
        tick();
        chk("sdr_off_vld", rx_data_vld, 1'b0);

        // Mid-pair abort and full re-warm
        sdr_mode_en = 1'b0;
        gen1_en = 1'b1;
        rx_en = 1'b1;
        wait_ready("abort_warm", 9);
        pad_data = 1'b1;
        tick();
        rx_en = 1'b0;
        tick();
        chk("abort_vld", rx_data_vld, 1'b0);
        chk("abort_ready", rx_ready, 1'b0);
        chk("abort_gen1", rx_buf_en_gen1, 1'b0);
        rx_en = 1'b1;
        wait_ready("rewarm", 9);

        // Mode change while ACTIVE returns to WARMUP
        gen1_en = 1'b0;
        tick();
        chk("modechg_ready", rx_ready, 1'b0);
        chk("modechg_gen1", rx_buf_en_gen1, 1'b0);
        chk("modechg_gen2", rx_buf_en_gen2, 1'b1);
        wait_ready("modechg_warm", 8);

        // Weak pull-up honoured while ACTIVE, then power-good loss
        wk_pu_en = 1'b1;
        tick();
        chk("wkpu_act", wkpu_en, 1'b1);
        chk("wkpd_act", wkpd_en, 1'b0);
        chk("wk_ready", rx_ready, 1'b1);
        pwrgoodrx = 1'b0;
        tick();
        chk_all_zero("pgloss");

        // Strap forces pull-down
        pwrgoodrx = 1'b1;
        rx_en = 1'b0;
        rst_strap = 1'b1;
        tick();
        chk("strap_wkpd", wkpd_en, 1'b1);
        chk("strap_wkpu", wkpu_en, 1'b0);
        chk("strap_gen1", rx_buf_en_gen1, 1'b0);
        chk("strap_ready", rx_ready, 1'b0);
        rst_strap = 1'b0;
        wk_pu_en = 1'b0;

        // Async wins over rx_en; bypass follows pad combinationally
        rx_en = 1'b1;
        rx_async_en = 1'b1;
        pad_data = 1'b1;
        tick();
        chk("async_gen1", rx_buf_en_gen1, 1'b1);
        chk("async_gen2", rx_buf_en_gen2, 1'b0);
        chk("async_ready", rx_ready, 1'b0);
        chk("async_data1", rx_async_data, 1'b1);
        pad_data = 1'b0; #1;
        chk("async_data0", rx_async_data, 1'b0);
        pad_data = 1'b1; #1;
        chk("async_data1b", rx_async_data, 1'b1);
        tick();
        tick();
        chk("async_stay_off", rx_ready, 1'b0);

        // Conflicting pull requests cancel; single request passes through
        wk_pu_en = 1'b1;
        wk_pd_en = 1'b1;
        tick();
        chk("wk_both_pu", wkpu_en, 1'b0);
        chk("wk_both_pd", wkpd_en, 1'b0);
        rx_async_en = 1'b0;
        rx_en = 1'b0;
        tick();
        chk("async_gated", rx_async_data, 1'b0);
        wk_pu_en = 1'b0;
        tick();
        chk("wk_pd_only_pd", wkpd_en, 1'b1);
        chk("wk_pd_only_pu", wkpu_en, 1'b0);

        tick();
        chk_int("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_en_capture_xxpad.md
Name: rx_en_capture_xxpad

Overview:
Receive-side counterpart of the TX pad enable logic for one AIB IO pad. It enables the gen1 or gen2 RX buffer and the pad weak pulls, and sequences receiver warm-up through a small FSM. It also captures the buffered pad value as SDR or half-rate DDR even/odd pairs with a valid strobe, and provides a gated async bypass path.

Parameters:
WARMUP_CYC, 8, cycles spent in WARMUP before capture starts (0..255; 0 = go to ACTIVE on the next edge)
CNT_W, 8, warm-up counter width; must hold WARMUP_CYC

Ports:
clk  in  1  capture clock (forwarded RX clock domain)
rst_n  in  1  asynchronous active-low reset
pad_data  in  1  buffered pad value from the analog RX
pwrgoodrx  in  1  RX supply good
pwrgood  in  1  core supply good
rst_strap  in  1  pad reset strap
rx_en  in  1  synchronous receive enable
rx_async_en  in  1  async receive mode
sdr_mode_en  in  1  1 = SDR, 0 = DDR pairing
gen1_en  in  1  1 = gen1 buffer, 0 = gen2 buffer
wk_pu_en  in  1  weak pull-up request
wk_pd_en  in  1  weak pull-down request
rx_buf_en_gen1  out  1  gen1 receiver enable
rx_buf_en_gen2  out  1  gen2 receiver enable
wkpu_en  out  1  weak pull-up enable
wkpd_en  out  1  weak pull-down enable
rx_async_data  out  1  async data (combinational)
rx_data_even  out  1  captured even bit
rx_data_odd  out  1  captured odd bit
rx_data_vld  out  1  even/odd pair valid, one-cycle strobe
rx_ready  out  1  FSM in ACTIVE

Behaviour:
- rst_n low: state OFF, counter 0, pair phase EVEN. All registered outputs are 0.
- pg = pwrgoodrx & pwrgood; wk = wk_pu_en ^ wk_pd_en.
- Priority is evaluated each clk edge: rst_strap > !pg > rx_async_en > rx_en.
- rst_strap=1: next state OFF. wkpd_en=1, wkpu_en=0, buffers 0, vld 0.
- pg=0: next state OFF. Every output is 0.
- Weak pulls, otherwise: if wk, then wkpu_en=wk_pu_en and wkpd_en=wk_pd_en (registered). Both requests high, or both low, gives 0/0. Pulls are honoured in every FSM state.
- rx_async_en=1: next state OFF, rx_buf_en_gen1=1, rx_buf_en_gen2=0. rx_async_data = pad_data & async_active_q, where async_active_q is the registered async-path enable. rx_async_data is 0 in every other mode.
- FSM:
  - OFF: go to WARMUP when rx_en=1 (and rx_async_en=0). The counter loads 0.
  - WARMUP: the buffer enable is asserted per gen1_en and the counter increments. Go to ACTIVE on the edge where counter == WARMUP_CYC-1, or immediately if WARMUP_CYC=0.
  - ACTIVE: rx_ready=1 and capture runs.
  - Any state: rx_en=0 returns to OFF next edge. The partial pair is discarded and vld is 0 from that edge.
  - WARMUP/ACTIVE: a change in sdr_mode_en or gen1_en (compared against its registered copy) returns to WARMUP with the counter cleared and phase EVEN.
- Capture, ACTIVE only:
  - SDR: pad_data sampled at edge k gives even=odd=sample and vld=1 at edge k+1, every cycle.
  - DDR: the first sample after entering ACTIVE is EVEN. An EVEN sample at k and an ODD sample at k+1 are presented at edge k+2 with vld=1 for one cycle, so vld toggles every other cycle.
  - even/odd hold their last value while vld=0.
- Buffer enables: in WARMUP or ACTIVE, rx_buf_en_gen1=gen1_en|sdr_mode_en and rx_buf_en_gen2=~(gen1_en|sdr_mode_en). In OFF they are 0, except in async mode.
- Simultaneous rx_en=1 and rx_async_en=1: async wins and the FSM stays in OFF.

Decomposition:
- The shared package rx_xxpad_pkg holds:
  - the state enum (OFF, WARMUP, ACTIVE)
  - the phase enum (EVEN, ODD)
  - the mode encoding shared with the TX enable logic
- One sub-module is natural: rx_ddr_pair_capture (sample register, phase toggle, even/odd/vld output).

Test Plan:
- Warm-up timing: WARMUP_CYC=8, pg=1, rx_en rises at edge 0 -> WARMUP at edge 1, rx_ready=1 at edge 9, rx_buf_en_gen1=1 from edge 1 when gen1_en=1.
- DDR pairing: DDR mode, pad sequence 1,0,0,1 starting at the first ACTIVE edge -> vld pulses carry (even,odd)=(1,0) then (0,1), with vld low between them.
- SDR capture: SDR mode, pad 1,1,0 -> vld=1 every cycle, even=odd=1,1,0 at one-cycle latency.
- Mid-pair abort: rx_en drops after the EVEN sample -> no vld pulse, state OFF. Re-enabling restarts the full warm-up.
- Power good loss: pwrgoodrx drops while ACTIVE -> all outputs 0 within one edge. The rst_strap=1 case separately gives wkpd_en=1.
- Async and weak-pull priority: rx_async_en=1 with rx_en=1 -> rx_async_data follows pad_data, FSM stays OFF. wk_pu_en=wk_pd_en=1 gives wkpu_en=wkpd_en=0.
